// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the 5-stage pipeline sequencer: FSM state encodings,
// the hard-wired zero register and pipeline-register indices.
package pipe_ctrl_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_BOOT     = 2'd0;
  localparam state_t ST_RUN      = 2'd1;
  localparam state_t ST_MEM_WAIT = 2'd2;

  localparam logic [4:0] REG_X0 = 5'd0;

  // Bit positions of L1..L4 inside the block/clear vectors.
  localparam int STG_L1 = 0;
  localparam int STG_L2 = 1;
  localparam int STG_L3 = 2;
  localparam int STG_L4 = 3;

endpackage

// File: rtl/lu_hazard_det.sv
// Load-use hazard compare: the ID instruction reads the register a load in EX
// is about to write, so it must wait one cycle for the loaded data.
module lu_hazard_det
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] rd_l2,
  input  logic       ins_load_l2,
  input  logic [4:0] rs1_l1,
  input  logic [4:0] rs2_l1,
  input  logic       use_rs1_l1,
  input  logic       use_rs2_l1,
  output logic       lu_hit
);

  logic w_rs1_match;
  logic w_rs2_match;

  assign w_rs1_match = use_rs1_l1 && (rs1_l1 == rd_l2);
  assign w_rs2_match = use_rs2_l1 && (rs2_l1 == rd_l2);

  // x0 is never really written, so a load targeting it cannot create a dependency.
  assign lu_hit = ins_load_l2 && (rd_l2 != REG_X0) && (w_rs1_match || w_rs2_match);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: boot hold, load-use stall, EX-redirect flush and
// data-memory wait freeze with timeout, plus stall/flush performance counters.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int BOOT_CYCLES = 4,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rd_l2,
  input  logic             ins_load_l2,
  input  logic [4:0]       rs1_l1,
  input  logic [4:0]       rs2_l1,
  input  logic             use_rs1_l1,
  input  logic             use_rs2_l1,
  input  logic             redirect_ex,
  input  logic             dmem_req_l3,
  input  logic             dmem_ready,
  output logic             block_pc,
  output logic             block_l1,
  output logic             block_l2,
  output logic             block_l3,
  output logic             block_l4,
  output logic             clear_l1,
  output logic             clear_l2,
  output logic             clear_l3,
  output logic             clear_l4,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int BW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [BW-1:0] BOOT_LAST    = BW'(BOOT_CYCLES - 1);
  localparam logic [WW-1:0] WAIT_MAX     = WW'(MEM_TIMEOUT);
  localparam logic [WW-1:0] TIMEOUT_LAST = WW'(MEM_TIMEOUT - 1);

  state_t           r_state;
  logic [BW-1:0]    r_boot_cnt;
  logic [WW-1:0]    r_wait_cnt;
  logic             r_mem_err;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  state_t     w_state_nxt;
  logic       w_lu_hit;
  logic       w_block_pc;
  logic [3:0] w_blk;
  logic [3:0] w_clr;
  logic       w_flush;
  logic       w_wait_inc;
  logic       w_wait_clr;

  lu_hazard_det u_lu_det (
    .rd_l2       (rd_l2),
    .ins_load_l2 (ins_load_l2),
    .rs1_l1      (rs1_l1),
    .rs2_l1      (rs2_l1),
    .use_rs1_l1  (use_rs1_l1),
    .use_rs2_l1  (use_rs2_l1),
    .lu_hit      (w_lu_hit)
  );

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latch).
    w_state_nxt = r_state;
    w_block_pc  = 1'b0;
    w_blk       = '0;
    w_clr       = '0;
    w_flush     = 1'b0;
    w_wait_inc  = 1'b0;
    w_wait_clr  = 1'b0;
    case (r_state)
      ST_BOOT: begin
        w_block_pc = 1'b1;
        w_clr      = '1;
        if (r_boot_cnt == BOOT_LAST) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (dmem_req_l3 && !dmem_ready) begin
          w_block_pc                                = 1'b1;
          {w_blk[STG_L1], w_blk[STG_L2], w_blk[STG_L3]} = 3'b111;
          w_clr[STG_L4]                             = 1'b1;
          w_wait_inc                                = 1'b1;
          w_state_nxt                               = ST_MEM_WAIT;
        end else if (redirect_ex) begin
          // The ID instruction is squashed too, so any load-use hit on it is moot.
          w_clr[STG_L1] = 1'b1;
          w_clr[STG_L2] = 1'b1;
          w_flush       = 1'b1;
        end else if (w_lu_hit) begin
          w_block_pc    = 1'b1;
          w_blk[STG_L1] = 1'b1;
          w_clr[STG_L2] = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        if (!dmem_ready) begin
          w_block_pc                                = 1'b1;
          {w_blk[STG_L1], w_blk[STG_L2], w_blk[STG_L3]} = 3'b111;
          w_clr[STG_L4]                             = 1'b1;
          w_wait_inc                                = 1'b1;
        end else begin
          w_wait_clr  = 1'b1;
          w_state_nxt = ST_RUN;
        end
      end
      default: w_state_nxt = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      r_state     <= ST_BOOT;
      r_boot_cnt  <= '0;
      r_wait_cnt  <= '0;
      r_mem_err   <= 1'b0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_BOOT) r_boot_cnt <= r_boot_cnt + 1'b1;
      if (w_wait_clr) begin
        r_wait_cnt <= '0;
      end else if (w_wait_inc && (r_wait_cnt != WAIT_MAX)) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end
      // Flag rises on the edge where the wait count reaches the timeout.
      if (w_wait_inc && (r_wait_cnt == TIMEOUT_LAST)) r_mem_err <= 1'b1;
      if (w_block_pc && (r_state != ST_BOOT)) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_flush) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign block_pc  = w_block_pc;
  assign block_l1  = w_blk[STG_L1];
  assign block_l2  = w_blk[STG_L2];
  assign block_l3  = w_blk[STG_L3];
  assign block_l4  = w_blk[STG_L4];
  assign clear_l1  = w_clr[STG_L1];
  assign clear_l2  = w_clr[STG_L2];
  assign clear_l3  = w_clr[STG_L3];
  assign clear_l4  = w_clr[STG_L4];
  assign mem_err   = r_mem_err;
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

endmodule
